capture_ctrl: RTL and testbench

CAPTURE_CTRL -- requirements
Module: capture_ctrl

---
 rtl/capture_ctrl.sv | 166 ++++++++++++++++
 tb/tb_capture_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/capture_ctrl.sv
// capture_ctrl: trace-buffer write controller for a circular capture RAM.
//   clk, rst_n            clock, asynchronous active-low reset
//   run, clr_done         start a capture / acknowledge a finished one
//   trig                  trigger pulse, honoured only while armed
//   trig_pos, decimator   post-trigger sample count and sample period
//                         exponent, both latched when a capture starts
//   we, cap_en, cap_addr  RAM ownership, write strobe and write address
//   trace_end             address of the last sample of the finished capture
//   armed, triggered, capture_done  status flags
module capture_ctrl #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              clr_done,
  input  logic              trig,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [3:0]        decimator,
  output logic              we,
  output logic              cap_en,
  output logic [ADDR_W-1:0] cap_addr,
  output logic [ADDR_W-1:0] trace_end,
  output logic              armed,
  output logic              triggered,
  output logic              capture_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic [14:0]       dec_cnt_q, dec_cnt_d;
  logic [ADDR_W:0]   smpl_cnt_q, smpl_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] trace_end_q, trace_end_d;
  logic              triggered_q, triggered_d;
  logic [ADDR_W-1:0] trig_pos_q, trig_pos_d;
  logic [3:0]        dec_q, dec_d;

  logic              capturing;
  logic              sample;
  logic              start;
  logic [14:0]       dec_limit;
  logic [ADDR_W:0]   thresh;

  always_comb begin
    capturing = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
    dec_limit = (15'(1) << dec_q) - 15'd1;
    sample    = capturing && (dec_cnt_q == dec_limit);
    thresh    = DEPTH - {1'b0, trig_pos_q};
    start     = 1'b0;

    state_d     = state_q;
    cap_addr_d  = cap_addr_q;
    dec_cnt_d   = dec_cnt_q;
    smpl_cnt_d  = smpl_cnt_q;
    post_cnt_d  = post_cnt_q;
    trace_end_d = trace_end_q;
    triggered_d = triggered_q;
    trig_pos_d  = trig_pos_q;
    dec_d       = dec_q;

    // Counter updates are computed first so the state decisions below see
    // the post-edge values (a coincident sample counts before the decision).
    if (capturing) begin
      dec_cnt_d = sample ? '0 : dec_cnt_q + 15'd1;
      if (sample) begin
        cap_addr_d = cap_addr_q + ADDR_W'(1);
        if (smpl_cnt_q != DEPTH) begin
          smpl_cnt_d = smpl_cnt_q + (ADDR_W+1)'(1);
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (run) start = 1'b1;
      end
      S_PRE: begin
        if (smpl_cnt_d >= thresh) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (trig) begin
          if (trig_pos_q != '0) begin
            state_d     = S_POST;
            triggered_d = 1'b1;
            post_cnt_d  = '0;
          end else begin
            state_d     = S_DONE;
            trace_end_d = cap_addr_d - ADDR_W'(1);
          end
        end
      end
      S_POST: begin
        if (sample) post_cnt_d = post_cnt_q + ADDR_W'(1);
        if (post_cnt_d == trig_pos_q) begin
          state_d     = S_DONE;
          trace_end_d = cap_addr_d - ADDR_W'(1);
        end
      end
      S_DONE: begin
        if (run) begin
          start = 1'b1;
        end else if (clr_done) begin
          state_d     = S_IDLE;
          triggered_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start) begin
      state_d     = S_PRE;
      cap_addr_d  = '0;
      dec_cnt_d   = '0;
      smpl_cnt_d  = '0;
      post_cnt_d  = '0;
      triggered_d = 1'b0;
      trig_pos_d  = trig_pos;
      dec_d       = decimator;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cap_addr_q  <= '0;
      dec_cnt_q   <= '0;
      smpl_cnt_q  <= '0;
      post_cnt_q  <= '0;
      trace_end_q <= '0;
      triggered_q <= 1'b0;
      trig_pos_q  <= '0;
      dec_q       <= '0;
    end else begin
      state_q     <= state_d;
      cap_addr_q  <= cap_addr_d;
      dec_cnt_q   <= dec_cnt_d;
      smpl_cnt_q  <= smpl_cnt_d;
      post_cnt_q  <= post_cnt_d;
      trace_end_q <= trace_end_d;
      triggered_q <= triggered_d;
      trig_pos_q  <= trig_pos_d;
      dec_q       <= dec_d;
    end
  end

  // Every output comes from a flop or from the state alone.
  assign we           = capturing;
  assign cap_en       = sample;
  assign cap_addr     = cap_addr_q;
  assign trace_end    = trace_end_q;
  assign armed        = (state_q == S_ARMED);
  assign triggered    = triggered_q;
  assign capture_done = (state_q == S_DONE);

endmodule

// File: tb/tb_capture_ctrl.sv
module tb_capture_ctrl;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n, run, clr_done, trig;
  logic [ADDR_W-1:0] trig_pos;
  logic [3:0]        decimator;
  logic              we, cap_en, armed, triggered, capture_done;
  logic [ADDR_W-1:0] cap_addr, trace_end;

  capture_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .clr_done     (clr_done),
    .trig         (trig),
    .trig_pos     (trig_pos),
    .decimator    (decimator),
    .we           (we),
    .cap_en       (cap_en),
    .cap_addr     (cap_addr),
    .trace_end    (trace_end),
    .armed        (armed),
    .triggered    (triggered),
    .capture_done (capture_done)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          exp_trace = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_we", we, 0);
    chk("rst_cap_en", cap_en, 0);
    chk("rst_cap_addr", cap_addr, 0);
    chk("rst_trace_end", trace_end, 0);
    chk("rst_armed", armed, 0);
    chk("rst_triggered", triggered, 0);
    chk("rst_done", capture_done, 0);
  endtask

  // IDLE: trig and clr_done must be ignored and nothing written.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      run       = 1'b0;
      clr_done  = ($urandom_range(0, 3) == 0);
      trig      = ($urandom_range(0, 1) == 1);
      decimator = 4'($urandom);
      trig_pos  = ADDR_W'($urandom);
      @(negedge clk);
      chk("idle_we", we, 0);
      chk("idle_cap_en", cap_en, 0);
      chk("idle_armed", armed, 0);
      chk("idle_triggered", triggered, 0);
      chk("idle_done", capture_done, 0);
      chk("idle_trace_end", trace_end, exp_trace);
    end
  endtask

  // DONE: status holds while trig and parameter inputs wiggle.
  task automatic done_hold(input int n, input bit trg);
    for (int i = 0; i < n; i++) begin
      run       = 1'b0;
      clr_done  = 1'b0;
      trig      = ($urandom_range(0, 1) == 1);
      decimator = 4'($urandom);
      trig_pos  = ADDR_W'($urandom);
      @(negedge clk);
      chk("done_we", we, 0);
      chk("done_cap_en", cap_en, 0);
      chk("done_flag", capture_done, 1);
      chk("done_armed", armed, 0);
      chk("done_triggered", triggered, trg);
      chk("done_trace_end", trace_end, exp_trace);
    end
  endtask

  task automatic clr_to_idle(input int n);
    run      = 1'b0;
    clr_done = 1'b1;
    trig     = ($urandom_range(0, 1) == 1);
    @(negedge clk);
    chk("clr_done_flag", capture_done, 0);
    chk("clr_triggered", triggered, 0);
    chk("clr_we", we, 0);
    chk("clr_trace_end", trace_end, exp_trace);
    idle_cycles(n);
  endtask

  // One capture, checked cycle by cycle against arithmetic expectations.
  // Cycle 0 is the first cycle after the run edge; with period per = 2^d the
  // k-th write (k>=1) lands in cycle k*per-1 at address (k-1) mod DEPTH.
  // Armed starts after DEPTH-p writes; the first trig in armed at cycle
  // c_trig owns every write up to and including that cycle, then p more
  // writes follow (none when p==0).
  task automatic capture(input int d, input int p, input int trig_off,
                         input bit noise, input bit with_clr, input int abort_off);
    int per, c_arm, c_trig, pre_w, total, done_c, abort_c;
    per     = 1 << d;
    c_arm   = (DEPTH - p) * per;
    c_trig  = c_arm + trig_off;
    pre_w   = (c_trig + 1) / per;
    total   = (p == 0) ? pre_w : pre_w + p;
    done_c  = (p == 0) ? c_trig + 1 : total * per;
    abort_c = (abort_off < 0) ? -1 : c_trig + 1 + abort_off;

    decimator = 4'(d);
    trig_pos  = ADDR_W'(p);
    run       = 1'b1;
    clr_done  = with_clr;
    trig      = 1'b0;
    for (int c = 0; c <= done_c; c++) begin
      @(negedge clk);
      if (c == done_c) exp_trace = (total - 1) % DEPTH;
      chk("we", we, (c < done_c));
      chk("cap_en", cap_en, (c < done_c) && ((c + 1) % per == 0));
      chk("cap_addr", cap_addr, (c / per) % DEPTH);
      chk("armed", armed, (c >= c_arm) && (c <= c_trig));
      chk("triggered", triggered, (p > 0) && (c > c_trig));
      chk("capture_done", capture_done, (c == done_c));
      chk("trace_end", trace_end, exp_trace);
      if (c == abort_c) begin
        run      = 1'b0;
        clr_done = 1'b0;
        trig     = 1'b0;
        #1 rst_n = 1'b0;
        #1 exp_trace = 0;
        check_reset_outputs();
        #1 rst_n = 1'b1;
        return;
      end
      run      = noise && (c < done_c) && ($urandom_range(0, 7) == 0);
      clr_done = noise && (c < done_c) && ($urandom_range(0, 7) == 0);
      trig     = (c == c_trig) ||
                 (noise && (c < c_arm) && ((c == c_arm - 1) || ($urandom_range(0, 7) == 0))) ||
                 (noise && (c > c_trig) && (c < done_c) && ($urandom_range(0, 3) == 0));
      if (noise) begin
        decimator = 4'($urandom);
        trig_pos  = ADDR_W'($urandom);
      end
    end
  endtask

  initial begin
    int p;
    rst_n     = 1'b0;
    run       = 1'b0;
    clr_done  = 1'b0;
    trig      = 1'b0;
    trig_pos  = '0;
    decimator = '0;
    #2 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(20);

    // Full-speed capture, trig in the first armed cycle.
    capture(0, 100, 0, 1'b0, 1'b0, -1);
    done_hold(4, 1'b1);
    clr_to_idle(6);

    // Decimated capture with ignored trig/run/clr_done pulses around it.
    capture(2, 300, int'($urandom_range(0, 20)), 1'b1, 1'b0, -1);
    done_hold(3, 1'b1);

    // run+clr_done together in DONE; trig_pos=0 with trig on write 600.
    capture(0, 0, 87, 1'b1, 1'b1, -1);
    done_hold(3, 1'b0);

    // Restart from DONE, then reset part-way through the post-trigger phase.
    p = int'($urandom_range(2, 400));
    capture(1, p, int'($urandom_range(0, 10)), 1'b1, 1'b0,
            int'($urandom_range(0, (p - 1) * 2 - 1)));
    idle_cycles(12);

    capture(int'($urandom_range(0, 2)), int'($urandom_range(1, DEPTH - 1)),
            int'($urandom_range(0, 25)), 1'b1, 1'b0, -1);
    done_hold(2, 1'b1);
    clr_to_idle(3);

    for (int k = 0; k < 4; k++) begin
      p = int'($urandom_range(0, DEPTH - 1));
      capture(int'($urandom_range(0, 1)), p, int'($urandom_range(0, 30)),
              1'b1, k[0], -1);
      done_hold(2, (p != 0));
    end
    clr_to_idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
